// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the QSPI pad arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    GUARD = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE   = 2'b00;
  localparam logic [1:0] OWNER_R0     = 2'b01;
  localparam logic [1:0] OWNER_R1     = 2'b10;
  localparam logic [3:0] PAD_IDLE_OEB = 4'hF;

  // Width of a counter that must hold 0..max(x,1) without wrapping.
  function automatic int cnt_width(input int x);
    return $clog2(((x < 1) ? 1 : x) + 1);
  endfunction

endpackage

// File: rtl/spi_pad_arbiter.sv
// Two-master QSPI pad arbiter: registered grant, ownership changes only at
// cs_n-high boundaries, followed by a guard gap; pads are a combinational owner mux.
module spi_pad_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   GUARD_CYC = 4,
  parameter int   MAX_HOLD  = 0,
  parameter logic CPOL      = 1'b0
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       r0_req,
  output logic       r0_gnt,
  input  logic       r0_sck,
  input  logic       r0_cs_n,
  input  logic [3:0] r0_dq_o,
  input  logic [3:0] r0_dq_oe,
  output logic [3:0] r0_dq_i,
  input  logic       r1_req,
  output logic       r1_gnt,
  input  logic       r1_sck,
  input  logic       r1_cs_n,
  input  logic [3:0] r1_dq_o,
  input  logic [3:0] r1_dq_oe,
  output logic [3:0] r1_dq_i,
  output logic       pad_sck,
  output logic       pad_cs_n,
  output logic [3:0] pad_dq_o,
  output logic [3:0] pad_dq_oeb,
  input  logic [3:0] pad_dq_i,
  output logic [1:0] owner
);

  localparam int GW = cnt_width(GUARD_CYC);
  localparam int HW = cnt_width(MAX_HOLD);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [HW-1:0] HOLD_LIM   = HW'(MAX_HOLD);
  localparam logic          PREEMPT_EN = (MAX_HOLD != 0);

  arb_state_e    state_r;
  logic [GW-1:0] guard_cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic          rr_r;          // 1 = r1 favoured on a tie
  logic          gnt0_r;
  logic          gnt1_r;
  logic [1:0]    owner_r;

  logic any_req_s;
  logic pick_r1_s;
  logic rel0_s;
  logic rel1_s;

  assign any_req_s = r0_req | r1_req;
  assign pick_r1_s = r1_req & (~r0_req | rr_r);
  assign rel0_s = (~r0_req & r0_cs_n) |
                  (PREEMPT_EN & r1_req & (hold_cnt_r >= HOLD_LIM) & r0_cs_n);
  assign rel1_s = (~r1_req & r1_cs_n) |
                  (PREEMPT_EN & r0_req & (hold_cnt_r >= HOLD_LIM) & r1_cs_n);

  // Arbitration state, counters, round-robin pointer and registered grant.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r     <= IDLE;
      guard_cnt_r <= '0;
      hold_cnt_r  <= '0;
      rr_r        <= 1'b0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      owner_r     <= OWNER_NONE;
    end else begin
      case (state_r)
        IDLE, GUARD: begin
          if ((state_r == IDLE || guard_cnt_r == GUARD_LAST) && any_req_s) begin
            state_r    <= pick_r1_s ? GNT1 : GNT0;
            owner_r    <= pick_r1_s ? OWNER_R1 : OWNER_R0;
            gnt0_r     <= ~pick_r1_s;
            gnt1_r     <= pick_r1_s;
            rr_r       <= ~pick_r1_s;
            hold_cnt_r <= '0;
          end else if (state_r == GUARD && guard_cnt_r == GUARD_LAST) begin
            state_r <= IDLE;
          end else if (state_r == GUARD) begin
            guard_cnt_r <= guard_cnt_r + GW'(1);
          end
        end
        GNT0, GNT1: begin
          if ((state_r == GNT0) ? rel0_s : rel1_s) begin
            state_r     <= GUARD;
            guard_cnt_r <= '0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            owner_r     <= OWNER_NONE;
          end else if (((state_r == GNT0) ? r1_req : r0_req) && hold_cnt_r != HOLD_LIM) begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          owner_r <= OWNER_NONE;
        end
      endcase
    end
  end

  assign r0_gnt = gnt0_r;
  assign r1_gnt = gnt1_r;
  assign owner  = owner_r;

  // Pad mux: owner's signals pass straight through, otherwise idle levels.
  always_comb begin
    pad_sck    = CPOL;
    pad_cs_n   = 1'b1;
    pad_dq_o   = 4'h0;
    pad_dq_oeb = PAD_IDLE_OEB;
    r0_dq_i    = 4'h0;
    r1_dq_i    = 4'h0;
    case (state_r)
      GNT0: begin
        pad_sck    = r0_sck;
        pad_cs_n   = r0_cs_n;
        pad_dq_o   = r0_dq_o;
        pad_dq_oeb = ~r0_dq_oe;
        r0_dq_i    = pad_dq_i;
      end
      GNT1: begin
        pad_sck    = r1_sck;
        pad_cs_n   = r1_cs_n;
        pad_dq_o   = r1_dq_o;
        pad_dq_oeb = ~r1_dq_oe;
        r1_dq_i    = pad_dq_i;
      end
      default: begin
        pad_sck    = CPOL;
        pad_cs_n   = 1'b1;
        pad_dq_o   = 4'h0;
        pad_dq_oeb = PAD_IDLE_OEB;
      end
    endcase
  end

endmodule
